// File: rtl/rs_pkg.sv
// -----------------------------------------------------------------------------
// rs_pkg
// Shared definitions for the age-ordered ALU reservation station:
//   - internal opcode encoding (lui=1 ... andd=37)
//   - non_dep(): "no dependency" tag value for a given RoB index width
//   - rs_result_t: the {value, next_pc} pair produced by the ALU
// -----------------------------------------------------------------------------
package rs_pkg;

  localparam int XLEN = 32;

  // Internal opcode encoding shared with the dispatcher.
  localparam logic [6:0] lui   = 7'd1;
  localparam logic [6:0] auipc = 7'd2;
  localparam logic [6:0] jal   = 7'd3;
  localparam logic [6:0] jalr  = 7'd4;
  localparam logic [6:0] beq   = 7'd5;
  localparam logic [6:0] bne   = 7'd6;
  localparam logic [6:0] blt   = 7'd7;
  localparam logic [6:0] bge   = 7'd8;
  localparam logic [6:0] bltu  = 7'd9;
  localparam logic [6:0] bgeu  = 7'd10;
  localparam logic [6:0] lb    = 7'd11;
  localparam logic [6:0] lh    = 7'd12;
  localparam logic [6:0] lw    = 7'd13;
  localparam logic [6:0] lbu   = 7'd14;
  localparam logic [6:0] lhu   = 7'd15;
  localparam logic [6:0] sb    = 7'd16;
  localparam logic [6:0] sh    = 7'd17;
  localparam logic [6:0] sw    = 7'd18;
  localparam logic [6:0] addi  = 7'd19;
  localparam logic [6:0] slti  = 7'd20;
  localparam logic [6:0] sltiu = 7'd21;
  localparam logic [6:0] xori  = 7'd22;
  localparam logic [6:0] ori   = 7'd23;
  localparam logic [6:0] andi  = 7'd24;
  localparam logic [6:0] slli  = 7'd25;
  localparam logic [6:0] srli  = 7'd26;
  localparam logic [6:0] srai  = 7'd27;
  localparam logic [6:0] add   = 7'd28;
  localparam logic [6:0] sub   = 7'd29;
  localparam logic [6:0] sll   = 7'd30;
  localparam logic [6:0] slt   = 7'd31;
  localparam logic [6:0] sltu  = 7'd32;
  localparam logic [6:0] xorr  = 7'd33;
  localparam logic [6:0] srl   = 7'd34;
  localparam logic [6:0] sra   = 7'd35;
  localparam logic [6:0] orr   = 7'd36;
  localparam logic [6:0] andd  = 7'd37;

  // Tag with only the MSB set: operand value already present.
  function automatic int unsigned non_dep(input int unsigned rob_width);
    return 32'd1 << rob_width;
  endfunction

  // next_pc is carried at XLEN width; the station supports ADDR_WIDTH <= XLEN.
  typedef struct packed {
    logic [XLEN-1:0] value;
    logic [XLEN-1:0] next_pc;
  } rs_result_t;

endpackage

// File: rtl/rs_alu.sv
// -----------------------------------------------------------------------------
// rs_alu
// Purely combinational execute stage for one reservation-station entry.
// Ports:
//   opcode  in   7           internal opcode (rs_pkg encoding)
//   vj, vk  in   32          source operand values
//   imm     in   32          immediate
//   pc      in   ADDR_WIDTH  instruction pc
//   result  out  rs_result_t {value, next_pc}; next_pc is zero for non-control ops
// Branches return taken (1/0) in value; jal/jalr return pc+4 in value.
// Unknown opcodes (including loads/stores) produce value 0, next_pc 0.
// -----------------------------------------------------------------------------
module rs_alu
  import rs_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [6:0]            opcode,
  input  logic [XLEN-1:0]       vj,
  input  logic [XLEN-1:0]       vk,
  input  logic [XLEN-1:0]       imm,
  input  logic [ADDR_WIDTH-1:0] pc,
  output rs_result_t            result
);

  logic [XLEN-1:0] pc_x;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_plus_imm;
  logic [XLEN-1:0] jalr_tgt;
  logic            taken;

  // Targets are trimmed to the pc width and then zero-extended back.
  assign pc_x        = XLEN'(pc);
  assign pc_plus4    = XLEN'(ADDR_WIDTH'(pc_x + 32'd4));
  assign pc_plus_imm = XLEN'(ADDR_WIDTH'(pc_x + imm));
  assign jalr_tgt    = XLEN'(ADDR_WIDTH'((vj + imm) & ~32'd1));

  always_comb begin
    taken = 1'b0;
    case (opcode)
      beq:     taken = (vj == vk);
      bne:     taken = (vj != vk);
      blt:     taken = ($signed(vj) <  $signed(vk));
      bge:     taken = ($signed(vj) >= $signed(vk));
      bltu:    taken = (vj <  vk);
      bgeu:    taken = (vj >= vk);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every path of a combinational block must assign every output;
    // the default here is what keeps synthesis from inferring a latch.
    result = '0;
    case (opcode)
      lui:   result.value = imm;
      auipc: result.value = pc_x + imm;
      jal: begin
        result.value   = pc_x + 32'd4;
        result.next_pc = pc_plus_imm;
      end
      jalr: begin
        result.value   = pc_x + 32'd4;
        result.next_pc = jalr_tgt;
      end
      beq, bne, blt, bge, bltu, bgeu: begin
        result.value   = XLEN'(taken);
        result.next_pc = taken ? pc_plus_imm : pc_plus4;
      end
      addi:  result.value = vj + imm;
      slti:  result.value = XLEN'($signed(vj) < $signed(imm));
      sltiu: result.value = XLEN'(vj < imm);
      xori:  result.value = vj ^ imm;
      ori:   result.value = vj | imm;
      andi:  result.value = vj & imm;
      slli:  result.value = vj << imm[4:0];
      srli:  result.value = vj >> imm[4:0];
      srai:  result.value = $signed(vj) >>> imm[4:0];
      add:   result.value = vj + vk;
      sub:   result.value = vj - vk;
      sll:   result.value = vj << vk[4:0];
      slt:   result.value = XLEN'($signed(vj) < $signed(vk));
      sltu:  result.value = XLEN'(vj < vk);
      xorr:  result.value = vj ^ vk;
      srl:   result.value = vj >> vk[4:0];
      sra:   result.value = $signed(vj) >>> vk[4:0];
      orr:   result.value = vj | vk;
      andd:  result.value = vj & vk;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rs_age_issue.sv
// -----------------------------------------------------------------------------
// rs_age_issue
// ALU/branch/jump reservation station with RS_SIZE entries, NUM_CDB snooped
// broadcast ports and oldest-ready-first issue through an age matrix.
// The selected entry is executed by rs_alu and registered into RSCDB_* under
// a valid/grant handshake with the CDB arbiter.
//
// Ports:
//   Sys_clk, Sys_rst (async, active-high), Sys_rdy (global enable)
//   DPRS_*           dispatch interface (en, pc, Qj/Qk tags, Vj/Vk, imm,
//                    opcode, RoB_index)
//   RSDP_full, RSDP_free_cnt   idle-entry status to the dispatcher
//   CDB_en, CDB_RoB_index, CDB_value   packed broadcast ports (port p at
//                    [p*W +: W])
//   RSCDB_en, RSCDB_RoB_index, RSCDB_value, RSCDB_next_pc   registered result
//   CDBRS_grant      arbiter accepts the current result
//   RoBRS_flush      synchronous mispredict flush
//
// Optional build macro RS_PERF_CNT_EN adds RS_perf_issue, RS_perf_stall and
// RS_perf_full (32-bit wrapping counters, cleared only by reset).
// ADDR_WIDTH must not exceed 32.
// -----------------------------------------------------------------------------
module rs_age_issue
  import rs_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int RoB_WIDTH  = 8,
  parameter int RS_WIDTH   = 3,
  parameter int NUM_CDB    = 2
) (
  input  logic                      Sys_clk,
  input  logic                      Sys_rst,
  input  logic                      Sys_rdy,
  input  logic                      DPRS_en,
  input  logic [ADDR_WIDTH-1:0]     DPRS_pc,
  input  logic [RoB_WIDTH:0]        DPRS_Qj,
  input  logic [RoB_WIDTH:0]        DPRS_Qk,
  input  logic [31:0]               DPRS_Vj,
  input  logic [31:0]               DPRS_Vk,
  input  logic [31:0]               DPRS_imm,
  input  logic [6:0]                DPRS_opcode,
  input  logic [RoB_WIDTH-1:0]      DPRS_RoB_index,
  output logic                      RSDP_full,
  output logic [RS_WIDTH:0]         RSDP_free_cnt,
  input  logic [NUM_CDB-1:0]        CDB_en,
  input  logic [NUM_CDB*RoB_WIDTH-1:0] CDB_RoB_index,
  input  logic [NUM_CDB*32-1:0]     CDB_value,
  output logic                      RSCDB_en,
  output logic [RoB_WIDTH-1:0]      RSCDB_RoB_index,
  output logic [31:0]               RSCDB_value,
  output logic [ADDR_WIDTH-1:0]     RSCDB_next_pc,
  input  logic                      CDBRS_grant,
  input  logic                      RoBRS_flush
`ifdef RS_PERF_CNT_EN
  ,
  output logic [31:0]               RS_perf_issue,
  output logic [31:0]               RS_perf_stall,
  output logic [31:0]               RS_perf_full
`endif
);

  localparam int RS_SIZE = 1 << RS_WIDTH;

  typedef logic [RoB_WIDTH:0] tag_t;
  localparam tag_t NON_DEP = tag_t'(non_dep(RoB_WIDTH));

  // Entry payload
  logic [6:0]            op_q  [RS_SIZE];
  logic [ADDR_WIDTH-1:0] pc_q  [RS_SIZE];
  tag_t                  qj_q  [RS_SIZE];
  tag_t                  qk_q  [RS_SIZE];
  logic [31:0]           vj_q  [RS_SIZE];
  logic [31:0]           vk_q  [RS_SIZE];
  logic [31:0]           imm_q [RS_SIZE];
  logic [RoB_WIDTH-1:0]  rob_q [RS_SIZE];

  // Control state; older[i][j]=1 means entry i was dispatched before entry j.
  logic [RS_SIZE-1:0]                busy, busy_n;
  logic [RS_SIZE-1:0][RS_SIZE-1:0]   older, older_n;

  logic [RS_SIZE-1:0] ready, cand;
  logic [RS_SIZE-1:0] wake_j, wake_k;
  logic [31:0]        wake_vj [RS_SIZE];
  logic [31:0]        wake_vk [RS_SIZE];
  logic               hit_j, hit_k;
  logic               cap_j, cap_k;
  logic [31:0]        cap_vj, cap_vk;

  logic [RS_WIDTH-1:0] idle_head, sel;
  logic [RS_WIDTH:0]   free_cnt;
  logic                any_ready, dispatch, issue;

  logic [RoB_WIDTH-1:0] cdb_tag [NUM_CDB];
  logic [31:0]          cdb_val [NUM_CDB];
  rs_result_t           alu_res;

  always_comb begin
    for (int p = 0; p < NUM_CDB; p++) begin
      cdb_tag[p] = CDB_RoB_index[p*RoB_WIDTH +: RoB_WIDTH];
      cdb_val[p] = CDB_value[p*32 +: 32];
    end
  end

  // Searches the broadcast ports for a tag; scanning downwards lets the
  // lowest-numbered matching port win.
  function automatic logic cdb_lookup(input tag_t tag, output logic [31:0] val);
    logic hit;
    hit = 1'b0;
    val = '0;
    for (int p = NUM_CDB - 1; p >= 0; p--) begin
      if (!tag[RoB_WIDTH] && CDB_en[p] && (cdb_tag[p] == tag[RoB_WIDTH-1:0])) begin
        hit = 1'b1;
        val = cdb_val[p];
      end
    end
    return hit;
  endfunction

  // Operand capture at dispatch and wakeup of resident entries.
  always_comb begin
    cap_vj = '0;
    cap_vk = '0;
    hit_j  = 1'b0;
    hit_k  = 1'b0;
    cap_j  = cdb_lookup(DPRS_Qj, cap_vj);
    cap_k  = cdb_lookup(DPRS_Qk, cap_vk);
    for (int i = 0; i < RS_SIZE; i++) begin
      wake_vj[i] = '0;
      wake_vk[i] = '0;
      hit_j      = cdb_lookup(qj_q[i], wake_vj[i]);
      hit_k      = cdb_lookup(qk_q[i], wake_vk[i]);
      wake_j[i]  = busy[i] && hit_j;
      wake_k[i]  = busy[i] && hit_k;
    end
  end

  // Ready set, oldest-ready selection, idle head and free count.
  always_comb begin
    ready     = '0;
    cand      = '0;
    sel       = '0;
    idle_head = '0;
    free_cnt  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ready[i] = busy[i] && (qj_q[i] == NON_DEP) && (qk_q[i] == NON_DEP);
    end
    for (int i = 0; i < RS_SIZE; i++) begin
      cand[i] = ready[i];
      for (int j = 0; j < RS_SIZE; j++) begin
        if (ready[j] && older[j][i]) cand[i] = 1'b0;
      end
    end
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (cand[i])  sel       = RS_WIDTH'(i);
      if (!busy[i]) idle_head = RS_WIDTH'(i);
      if (!busy[i]) free_cnt  = free_cnt + 1'b1;
    end
  end

  assign any_ready     = |ready;
  assign RSDP_free_cnt = free_cnt;
  assign RSDP_full     = (free_cnt == '0);
  assign dispatch      = DPRS_en && !RSDP_full;
  assign issue         = any_ready && (!RSCDB_en || CDBRS_grant);

  // Next busy vector and age matrix.
  always_comb begin
    busy_n  = busy;
    older_n = older;
    if (issue) begin
      busy_n[sel] = 1'b0;
      for (int k = 0; k < RS_SIZE; k++) begin
        older_n[sel][k] = 1'b0;
        older_n[k][sel] = 1'b0;
      end
    end
    if (dispatch) begin
      // The newcomer is younger than everything still resident after issue.
      for (int k = 0; k < RS_SIZE; k++) begin
        older_n[idle_head][k] = 1'b0;
        older_n[k][idle_head] = busy_n[k];
      end
      busy_n[idle_head] = 1'b1;
    end
  end

  rs_alu #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_alu (
    .opcode(op_q[sel]),
    .vj    (vj_q[sel]),
    .vk    (vk_q[sel]),
    .imm   (imm_q[sel]),
    .pc    (pc_q[sel]),
    .result(alu_res)
  );

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      busy            <= '0;
      older           <= '0;
      RSCDB_en        <= 1'b0;
      RSCDB_RoB_index <= '0;
      RSCDB_value     <= '0;
      RSCDB_next_pc   <= '0;
    end else if (RoBRS_flush) begin
      busy     <= '0;
      older    <= '0;
      RSCDB_en <= 1'b0;
    end else if (Sys_rdy) begin
      busy  <= busy_n;
      older <= older_n;
      if (issue) begin
        RSCDB_en        <= 1'b1;
        RSCDB_RoB_index <= rob_q[sel];
        RSCDB_value     <= alu_res.value;
        RSCDB_next_pc   <= ADDR_WIDTH'(alu_res.next_pc);
      end else if (CDBRS_grant) begin
        RSCDB_en <= 1'b0;
      end
    end
  end

  // NOTE: the payload array has no reset; busy alone says whether an entry's
  // contents mean anything, so resetting the storage would only add cost.
  always_ff @(posedge Sys_clk) begin
    if (!Sys_rst && !RoBRS_flush && Sys_rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (wake_j[i]) begin
          qj_q[i] <= NON_DEP;
          vj_q[i] <= wake_vj[i];
        end
        if (wake_k[i]) begin
          qk_q[i] <= NON_DEP;
          vk_q[i] <= wake_vk[i];
        end
      end
      if (dispatch) begin
        op_q[idle_head]  <= DPRS_opcode;
        pc_q[idle_head]  <= DPRS_pc;
        imm_q[idle_head] <= DPRS_imm;
        rob_q[idle_head] <= DPRS_RoB_index;
        qj_q[idle_head]  <= cap_j ? NON_DEP : DPRS_Qj;
        vj_q[idle_head]  <= cap_j ? cap_vj  : DPRS_Vj;
        qk_q[idle_head]  <= cap_k ? NON_DEP : DPRS_Qk;
        vk_q[idle_head]  <= cap_k ? cap_vk  : DPRS_Vk;
      end
    end
  end

`ifdef RS_PERF_CNT_EN
  // Counters survive flush; only reset clears them.
  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      RS_perf_issue <= '0;
      RS_perf_stall <= '0;
      RS_perf_full  <= '0;
    end else if (Sys_rdy) begin
      if (RSCDB_en && CDBRS_grant)  RS_perf_issue <= RS_perf_issue + 32'd1;
      if (RSCDB_en && !CDBRS_grant) RS_perf_stall <= RS_perf_stall + 32'd1;
      if (RSDP_full && DPRS_en)     RS_perf_full  <= RS_perf_full + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rs_age_issue.sv
// -----------------------------------------------------------------------------
// tb_rs_age_issue
// Directed bench for rs_age_issue (default parameters): a table of single-op
// vectors for the ALU results plus hand-written sequences for latency, hold,
// age ordering, CDB wakeup/capture, full, flush, enable and async reset.
// -----------------------------------------------------------------------------
module tb_rs_age_issue;
  import rs_pkg::*;

  localparam logic [8:0] ND = 9'h100;

  logic        Sys_clk = 1'b0;
  logic        Sys_rst;
  logic        Sys_rdy;
  logic        DPRS_en;
  logic [31:0] DPRS_pc;
  logic [8:0]  DPRS_Qj, DPRS_Qk;
  logic [31:0] DPRS_Vj, DPRS_Vk, DPRS_imm;
  logic [6:0]  DPRS_opcode;
  logic [7:0]  DPRS_RoB_index;
  logic        RSDP_full;
  logic [3:0]  RSDP_free_cnt;
  logic [1:0]  CDB_en;
  logic [15:0] CDB_RoB_index;
  logic [63:0] CDB_value;
  logic        RSCDB_en;
  logic [7:0]  RSCDB_RoB_index;
  logic [31:0] RSCDB_value;
  logic [31:0] RSCDB_next_pc;
  logic        CDBRS_grant;
  logic        RoBRS_flush;
`ifdef RS_PERF_CNT_EN
  logic [31:0] RS_perf_issue, RS_perf_stall, RS_perf_full;
`endif

  rs_age_issue dut (
    .Sys_clk        (Sys_clk),
    .Sys_rst        (Sys_rst),
    .Sys_rdy        (Sys_rdy),
    .DPRS_en        (DPRS_en),
    .DPRS_pc        (DPRS_pc),
    .DPRS_Qj        (DPRS_Qj),
    .DPRS_Qk        (DPRS_Qk),
    .DPRS_Vj        (DPRS_Vj),
    .DPRS_Vk        (DPRS_Vk),
    .DPRS_imm       (DPRS_imm),
    .DPRS_opcode    (DPRS_opcode),
    .DPRS_RoB_index (DPRS_RoB_index),
    .RSDP_full      (RSDP_full),
    .RSDP_free_cnt  (RSDP_free_cnt),
    .CDB_en         (CDB_en),
    .CDB_RoB_index  (CDB_RoB_index),
    .CDB_value      (CDB_value),
    .RSCDB_en       (RSCDB_en),
    .RSCDB_RoB_index(RSCDB_RoB_index),
    .RSCDB_value    (RSCDB_value),
    .RSCDB_next_pc  (RSCDB_next_pc),
    .CDBRS_grant    (CDBRS_grant),
    .RoBRS_flush    (RoBRS_flush)
`ifdef RS_PERF_CNT_EN
    ,
    .RS_perf_issue  (RS_perf_issue),
    .RS_perf_stall  (RS_perf_stall),
    .RS_perf_full   (RS_perf_full)
`endif
  );

  always #5 Sys_clk = ~Sys_clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [6:0]  op;
    logic [31:0] vj, vk, imm, pc;
    logic [31:0] value, npc;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic [6:0] op, input logic [31:0] vj, vk, imm, pc,
                              input logic [31:0] value, npc);
    vec_t v;
    v.op = op; v.vj = vj; v.vk = vk; v.imm = imm; v.pc = pc;
    v.value = value; v.npc = npc;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Inputs change on the falling edge; outputs are read there as well.
  task automatic tick();
    @(posedge Sys_clk);
    @(negedge Sys_clk);
  endtask

  task automatic disp(input logic [6:0] op, input logic [8:0] qj, input logic [31:0] vj,
                      input logic [8:0] qk, input logic [31:0] vk,
                      input logic [31:0] imm, input logic [31:0] pc, input logic [7:0] rob);
    DPRS_opcode = op; DPRS_Qj = qj; DPRS_Vj = vj; DPRS_Qk = qk; DPRS_Vk = vk;
    DPRS_imm = imm; DPRS_pc = pc; DPRS_RoB_index = rob; DPRS_en = 1'b1;
    tick();
    DPRS_en = 1'b0;
  endtask

  task automatic cdb(input logic [1:0] en, input logic [7:0] t0, input logic [31:0] v0,
                     input logic [7:0] t1, input logic [31:0] v1);
    CDB_en = en;
    CDB_RoB_index = {t1, t0};
    CDB_value = {v1, v0};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(addi,  32'd5,        32'd0,        32'd7,        32'h0,    32'd12,       32'h0);
    vecs[1]  = mk(sub,   32'd3,        32'd5,        32'd0,        32'h0,    32'hFFFFFFFE, 32'h0);
    vecs[2]  = mk(sra,   32'h80000000, 32'h24,       32'd0,        32'h0,    32'hF8000000, 32'h0);
    vecs[3]  = mk(srli,  32'h80000000, 32'd0,        32'h21,       32'h0,    32'h40000000, 32'h0);
    vecs[4]  = mk(slt,   32'hFFFFFFFF, 32'd1,        32'd0,        32'h0,    32'd1,        32'h0);
    vecs[5]  = mk(sltu,  32'hFFFFFFFF, 32'd1,        32'd0,        32'h0,    32'd0,        32'h0);
    vecs[6]  = mk(bltu,  32'd1,        32'hFFFFFFFF, 32'h20,       32'h100,  32'd1,        32'h120);
    vecs[7]  = mk(beq,   32'd2,        32'd3,        32'h20,       32'h100,  32'd0,        32'h104);
    vecs[8]  = mk(blt,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFF0, 32'h100,  32'd1,        32'hF0);
    vecs[9]  = mk(bge,   32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,  32'd0,        32'h104);
    vecs[10] = mk(jal,   32'd0,        32'd0,        32'h40,       32'h200,  32'h204,      32'h240);
    vecs[11] = mk(jalr,  32'h203,      32'd0,        32'd0,        32'h300,  32'h304,      32'h202);
    vecs[12] = mk(lui,   32'd0,        32'd0,        32'h12345000, 32'h0,    32'h12345000, 32'h0);
    vecs[13] = mk(auipc, 32'd0,        32'd0,        32'h2000,     32'h1000, 32'h3000,     32'h0);
    vecs[14] = mk(xorr,  32'hF0F0,     32'h0FF0,     32'd0,        32'h0,    32'hFF00,     32'h0);
    vecs[15] = mk(sll,   32'd1,        32'h3F,       32'd0,        32'h0,    32'h80000000, 32'h0);
    vecs[16] = mk(andi,  32'hFF,       32'd0,        32'h0F,       32'h0,    32'h0F,       32'h0);
    vecs[17] = mk(lw,    32'd5,        32'd5,        32'd5,        32'h100,  32'd0,        32'h0);
    vecs[18] = mk(sltiu, 32'd5,        32'd0,        32'hFFFFFFFF, 32'h0,    32'd1,        32'h0);
    vecs[19] = mk(bgeu,  32'hFFFFFFFF, 32'd1,        32'd8,        32'h10,   32'd1,        32'h18);
    vecs[20] = mk(bne,   32'd7,        32'd7,        32'd8,        32'h10,   32'd0,        32'h14);
    vecs[21] = mk(orr,   32'hF000,     32'h000F,     32'd0,        32'h0,    32'hF00F,     32'h0);
    vecs[22] = mk(7'd0,  32'd9,        32'd9,        32'd9,        32'h40,   32'd0,        32'h0);

    Sys_rst = 1'b1; Sys_rdy = 1'b1; DPRS_en = 1'b0; DPRS_pc = '0;
    DPRS_Qj = ND; DPRS_Qk = ND; DPRS_Vj = '0; DPRS_Vk = '0; DPRS_imm = '0;
    DPRS_opcode = '0; DPRS_RoB_index = '0; CDBRS_grant = 1'b0; RoBRS_flush = 1'b0;
    cdb(2'b00, 8'd0, 32'd0, 8'd0, 32'd0);

    // Reset state
    #2;
    check("reset en", 64'(RSCDB_en), 64'd0);
    check("reset value", 64'(RSCDB_value), 64'd0);
    check("reset next_pc", 64'(RSCDB_next_pc), 64'd0);
    check("reset rob", 64'(RSCDB_RoB_index), 64'd0);
    check("reset free_cnt", 64'(RSDP_free_cnt), 64'd8);
    check("reset full", 64'(RSDP_full), 64'd0);
    @(negedge Sys_clk);
    @(negedge Sys_clk);
    Sys_rst = 1'b0;
    tick();

    // Table: one ready op at a time, result two edges after dispatch.
    CDBRS_grant = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      disp(vecs[i].op, ND, vecs[i].vj, ND, vecs[i].vk, vecs[i].imm, vecs[i].pc, 8'(i + 16));
      tick();
      check($sformatf("vec%0d en", i), 64'(RSCDB_en), 64'd1);
      check($sformatf("vec%0d value", i), 64'(RSCDB_value), 64'(vecs[i].value));
      check($sformatf("vec%0d next_pc", i), 64'(RSCDB_next_pc), 64'(vecs[i].npc));
      check($sformatf("vec%0d rob", i), 64'(RSCDB_RoB_index), 64'(i + 16));
      tick();
    end
    check("empty after table", 64'(RSDP_free_cnt), 64'd8);

    // Sys_rdy=0 freezes everything, including dispatch.
    Sys_rdy = 1'b0;
    disp(addi, ND, 32'd1, ND, 32'd0, 32'd1, 32'd0, 8'd5);
    check("rdy0 free_cnt", 64'(RSDP_free_cnt), 64'd8);
    tick();
    check("rdy0 en", 64'(RSCDB_en), 64'd0);
    Sys_rdy = 1'b1;

    // Latency and hold under grant=0.
    CDBRS_grant = 1'b0;
    disp(addi, ND, 32'd5, ND, 32'd0, 32'd7, 32'd0, 8'd3);
    check("latency en after dispatch edge", 64'(RSCDB_en), 64'd0);
    tick();
    check("latency en", 64'(RSCDB_en), 64'd1);
    check("latency value", 64'(RSCDB_value), 64'd12);
    check("latency rob", 64'(RSCDB_RoB_index), 64'd3);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("hold%0d en", k), 64'(RSCDB_en), 64'd1);
      check($sformatf("hold%0d value", k), 64'(RSCDB_value), 64'd12);
      check($sformatf("hold%0d rob", k), 64'(RSCDB_RoB_index), 64'd3);
    end
    CDBRS_grant = 1'b1;
    tick();
    check("grant with nothing ready", 64'(RSCDB_en), 64'd0);
    CDBRS_grant = 1'b0;

    // Age order: A lands in entry 1, B later in freed entry 0; A must go first.
    disp(addi, ND, 32'd0, ND, 32'd0, 32'd1, 32'd0, 8'd10);
    disp(addi, ND, 32'd100, ND, 32'd0, 32'd1, 32'd0, 8'd1);
    disp(addi, ND, 32'd200, ND, 32'd0, 32'd1, 32'd0, 8'd2);
    check("age held rob", 64'(RSCDB_RoB_index), 64'd10);
    check("age held value", 64'(RSCDB_value), 64'd1);
    check("age free_cnt", 64'(RSDP_free_cnt), 64'd6);
    CDBRS_grant = 1'b1;
    tick();
    check("age first rob", 64'(RSCDB_RoB_index), 64'd1);
    check("age first value", 64'(RSCDB_value), 64'd101);
    tick();
    check("age second rob", 64'(RSCDB_RoB_index), 64'd2);
    check("age second value", 64'(RSCDB_value), 64'd201);
    tick();
    check("age drained", 64'(RSCDB_en), 64'd0);

    // Wakeup from CDB port 1 (port 0 carries an unrelated tag).
    disp(add, 9'd9, 32'd0, ND, 32'd1, 32'd0, 32'd0, 8'd4);
    tick();
    check("wait on tag", 64'(RSCDB_en), 64'd0);
    cdb(2'b11, 8'd5, 32'h1111, 8'd9, 32'hDEAD);
    tick();
    cdb(2'b00, 8'd0, 32'd0, 8'd0, 32'd0);
    check("woken not yet issued", 64'(RSCDB_en), 64'd0);
    tick();
    check("wake en", 64'(RSCDB_en), 64'd1);
    check("wake value", 64'(RSCDB_value), 64'hDEAE);
    check("wake rob", 64'(RSCDB_RoB_index), 64'd4);
    tick();

    // Capture at dispatch; both ports match, port 0 wins.
    cdb(2'b11, 8'd9, 32'h100, 8'd9, 32'h200);
    disp(add, 9'd9, 32'd0, ND, 32'd1, 32'd0, 32'd0, 8'd6);
    cdb(2'b00, 8'd0, 32'd0, 8'd0, 32'd0);
    tick();
    check("capture en", 64'(RSCDB_en), 64'd1);
    check("capture value", 64'(RSCDB_value), 64'h101);
    check("capture rob", 64'(RSCDB_RoB_index), 64'd6);
    tick();

    // Fill with ops waiting on Qk; extra dispatch while full is ignored.
    CDBRS_grant = 1'b0;
    for (int i = 0; i < 8; i++) begin
      disp(add, ND, 32'(i), 9'(30 + i), 32'd0, 32'd0, 32'd0, 8'(40 + i));
    end
    check("full", 64'(RSDP_full), 64'd1);
    check("full free_cnt", 64'(RSDP_free_cnt), 64'd0);
    disp(addi, ND, 32'd1, ND, 32'd0, 32'd1, 32'd0, 8'd99);
    check("ignored free_cnt", 64'(RSDP_free_cnt), 64'd0);
    tick();
    check("ignored no issue", 64'(RSCDB_en), 64'd0);
    CDBRS_grant = 1'b1;
    cdb(2'b01, 8'd33, 32'h10, 8'd0, 32'd0);
    tick();
    cdb(2'b00, 8'd0, 32'd0, 8'd0, 32'd0);
    check("still full after wake", 64'(RSDP_full), 64'd1);
    tick();
    check("full wake en", 64'(RSCDB_en), 64'd1);
    check("full wake rob", 64'(RSCDB_RoB_index), 64'd43);
    check("full wake value", 64'(RSCDB_value), 64'h13);
    check("full deasserted", 64'(RSDP_full), 64'd0);
    check("free after issue", 64'(RSDP_free_cnt), 64'd1);

    // Drain two more (oldest first) to reach 5 busy with a pending result.
    CDBRS_grant = 1'b0;
    cdb(2'b11, 8'd30, 32'd0, 8'd31, 32'd0);
    tick();
    cdb(2'b00, 8'd0, 32'd0, 8'd0, 32'd0);
    check("held rob 43", 64'(RSCDB_RoB_index), 64'd43);
    CDBRS_grant = 1'b1;
    tick();
    check("oldest woken rob", 64'(RSCDB_RoB_index), 64'd40);
    tick();
    check("next woken rob", 64'(RSCDB_RoB_index), 64'd41);
    check("next woken value", 64'(RSCDB_value), 64'd1);
    check("five busy", 64'(RSDP_free_cnt), 64'd3);
    CDBRS_grant = 1'b0;

    // Flush with a pending result; the dispatch in the same cycle is dropped.
    RoBRS_flush = 1'b1;
    disp(addi, ND, 32'd1, ND, 32'd0, 32'd1, 32'd0, 8'd77);
    RoBRS_flush = 1'b0;
    check("flush en", 64'(RSCDB_en), 64'd0);
    check("flush free_cnt", 64'(RSDP_free_cnt), 64'd8);
    check("flush full", 64'(RSDP_full), 64'd0);
    tick();
    check("flush dispatch dropped", 64'(RSCDB_en), 64'd0);

    // Async reset in the middle of a cycle.
    disp(add, 9'd50, 32'd0, ND, 32'd0, 32'd0, 32'd0, 8'd8);
    disp(addi, ND, 32'd5, ND, 32'd0, 32'd7, 32'h40, 8'd3);
    tick();
    check("pre-reset en", 64'(RSCDB_en), 64'd1);
    #2;
    Sys_rst = 1'b1;
    #1;
    check("async reset en", 64'(RSCDB_en), 64'd0);
    check("async reset value", 64'(RSCDB_value), 64'd0);
    check("async reset rob", 64'(RSCDB_RoB_index), 64'd0);
    check("async reset free_cnt", 64'(RSDP_free_cnt), 64'd8);
    @(negedge Sys_clk);
    Sys_rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rs_age_issue.md
Name: rs_age_issue

Overview:
Parametrised successor to the single-CDB ALU reservation station. It holds RS_SIZE dispatched ALU/branch/jump instructions and snoops NUM_CDB broadcast ports for operand wakeup. Each cycle it issues the oldest ready entry, not the lowest-indexed one. The result sits in an output register under a valid/grant handshake with the CDB arbiter. The block sits between the dispatcher and the CDB arbiter, alongside the LSB.

Parameters:
ADDR_WIDTH, 32, pc width
RoB_WIDTH, 8, RoB index width; dependency tags are RoB_WIDTH+1 bits, and MSB=1 means no dependency (NON_DEP = 1<<RoB_WIDTH)
RS_WIDTH, 3, log2 of entry count; RS_SIZE = 1<<RS_WIDTH; legal range 1..5
NUM_CDB, 2, number of snooped broadcast ports; legal range 1..4

Ports:
Sys_clk  in  1  clock, rising edge
Sys_rst  in  1  reset, asynchronous, active-high
Sys_rdy  in  1  global enable; when 0, no state changes
DPRS_en  in  1  dispatch valid
DPRS_pc  in  ADDR_WIDTH  instruction pc
DPRS_Qj / DPRS_Qk  in  RoB_WIDTH+1  operand tags
DPRS_Vj / DPRS_Vk  in  32  operand values, valid when the matching tag is NON_DEP
DPRS_imm  in  32  immediate
DPRS_opcode  in  7  internal opcode (package encoding)
DPRS_RoB_index  in  RoB_WIDTH  destination RoB slot
RSDP_full  out  1  no idle entry
RSDP_free_cnt  out  RS_WIDTH+1  number of idle entries
CDB_en  in  NUM_CDB  per-port broadcast valid
CDB_RoB_index  in  NUM_CDB*RoB_WIDTH  packed tags; port p occupies bits [p*RoB_WIDTH +: RoB_WIDTH]
CDB_value  in  NUM_CDB*32  packed values
RSCDB_en  out  1  result valid
RSCDB_RoB_index  out  RoB_WIDTH  result tag
RSCDB_value  out  32  rd value, or branch taken flag (1/0)
RSCDB_next_pc  out  ADDR_WIDTH  branch/jump target; 0 for other ops
CDBRS_grant  in  1  arbiter accepts the result this cycle
RoBRS_flush  in  1  mispredict flush, synchronous

Behaviour:
- Reset (asynchronous): all busy=0, age matrix=0, RSCDB_en=0, RSCDB_RoB_index=0, RSCDB_value=0, RSCDB_next_pc=0, optional counters=0.
- Priority per edge: Sys_rst > RoBRS_flush > !Sys_rdy (hold) > normal. Flush clears busy, the age matrix and RSCDB_en in one cycle; dispatch in the flush cycle is dropped.
- Dispatch: when DPRS_en && !RSDP_full, the lowest-index idle entry (idle_head) is written.
  - The new entry is marked younger than every currently busy entry.
  - DPRS_en while full is ignored.
  - idle_head uses pre-edge busy, so a slot freed by issue in the same cycle is reusable next cycle.
- Dispatch-time capture: if DPRS_Qx is not NON_DEP and it matches any asserted CDB port this cycle, store Qx=NON_DEP and Vx=that port's value. Otherwise store the tag and value as given.
- Wakeup: every edge, each busy entry with Qx[RoB_WIDTH]==0 and Qx[RoB_WIDTH-1:0] equal to an asserted port's index gets Qx=NON_DEP and Vx=value. If several ports match, the lowest port index wins.
- Ready: busy && Qj==NON_DEP && Qk==NON_DEP, evaluated on registered state. An entry dispatched or woken at edge N is first eligible at edge N+1.
- Age order: RS_SIZE x RS_SIZE matrix, where older[i][j]=1 means i was dispatched before j. The issue candidate is the ready entry with no ready entry older than it.
- Issue: allowed when (!RSCDB_en || CDBRS_grant) and a ready entry exists.
  - Result registered at the edge, so latency is one cycle from ready to RSCDB_en.
  - The issued entry's busy is cleared and its matrix row/column are cleared.
- Hold: if RSCDB_en && !CDBRS_grant, the RSCDB_* outputs stay stable and nothing issues.
  - If granted with no ready entry, RSCDB_en=0 next cycle.
- Arithmetic: 32-bit wrapping. Shifts use the low 5 bits of Vk or imm. jal/jalr value = pc+4; jalr target = (Vj+imm)&~1. Branches produce value 1/0 and next_pc = taken ? pc+imm : pc+4. Unknown opcode gives value 0 and next_pc 0, and the entry still retires.
- RSDP_free_cnt and RSDP_full are combinational from registered busy.

Optional Feature:
RS_PERF_CNT_EN
- Defined: adds outputs RS_perf_issue (32b, issued results accepted by grant), RS_perf_stall (32b, cycles with RSCDB_en && !grant) and RS_perf_full (32b, cycles RSDP_full && DPRS_en). All three wrap, are cleared by reset only, and are not cleared by flush.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package rs_pkg: opcode constants lui=1 … andd=37 (unchanged encoding), NON_DEP function of RoB_WIDTH, and a struct for the result {value, next_pc}.
- Sub-module rs_alu: purely combinational; inputs opcode, Vj, Vk, imm, pc; outputs value and next_pc. It is instantiated once, on the selected entry.

Test Plan:
- Dispatch addi (Qj NON_DEP, Vj=5, imm=7, RoB 3) -> RSCDB_en=1 two edges after dispatch with value 12 and RoB 3. Hold grant=0 for 3 cycles -> outputs stable.
- Dispatch A (RoB 1) then B (RoB 2) into entries 1 and 0 (entry 0 freed earlier), both ready -> A issues first despite the higher index.
- Entry waits on tag 9; CDB port 1 broadcasts 9/0xDEAD -> entry issues add with Vj=0xDEAD. Repeat with the dispatch in the same cycle as the broadcast -> captured, no deadlock.
- Fill all 8 entries with unready ops -> RSDP_full=1 and free_cnt=0; a further DPRS_en is ignored. Wake one and grant it -> full deasserts the next cycle.
- Flush asserted while RSCDB_en=1 and 5 entries are busy -> next cycle RSCDB_en=0 and free_cnt=8. Assert async reset mid-cycle -> outputs are 0 immediately.
- bltu with Vj=1, Vk=0xFFFFFFFF, pc=0x100, imm=0x20 -> value 1, next_pc 0x120. jalr with Vj=0x203, imm=0 -> next_pc 0x202 and value pc+4.
